mem_responder: RTL
==================

# mem_responder

Slow-side responder for the data cache's memory port. It holds a word-addressable backing array of 2**AWIDTH words and serves read and write requests. Writes are posted through a small write buffer, and reads return after a fixed latency. Reads are strictly ordered behind every buffered write. It sits between the cache's port B and the rest of the memory system, and models the slow memory the cache is written against.

## Interface
- DWIDTH, 16: data word width.
- AWIDTH, 10: word address width; the array holds 2**AWIDTH words.
- RD_LAT, 4: read latency in cycles from read issue to data valid; minimum 1.
- WR_LAT, 3: cycles per buffered write to commit into the array; minimum 1.
- WB_DEPTH, 4: write buffer entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_wr  in  1  write request.
- i_wdata  in  DWIDTH  write data.
- i_waddr  in  AWIDTH  write word address.
- i_rd  in  1  read request.
- i_raddr  in  AWIDTH  read word address.
- o_ready  out  1  requests on i_wr/i_rd are accepted at an edge only while this is high.
- o_rdata  out  DWIDTH  read data; holds its last value between reads.
- o_rvalid  out  1  single-cycle pulse; o_rdata is valid while it is high.
- o_wb_empty  out  1  write buffer empty and no write in progress.

## Operation
- Acceptance:
  - A request is accepted at a rising edge where o_ready=1 and its strobe is high.
  - o_ready = !wb_full && !rd_pending.
  - Strobes seen while o_ready=0 are ignored; the requester holds them.
- Write path:
  - An accepted write pushes {addr, data} into the FIFO.
  - The head entry counts WR_LAT edges, then is written to the array and popped.
  - The next entry starts counting at that same edge.
  - Writes commit in acceptance order.
- Read path: an accepted read latches i_raddr and sets rd_pending. The FSM then runs:
  - IDLE: on read accept, go to WAIT_WB.
  - WAIT_WB: wait until the buffer is empty. The issue edge is the first edge where the buffer is empty, counting the acceptance edge itself. Go to RD_LAT.
  - RD_LAT: at the issue edge, sample the array into a data register and load the counter with RD_LAT.
  - At counter expiry, o_rdata is updated and o_rvalid pulses for one cycle. rd_pending clears and the FSM returns to IDLE.
- Simultaneous i_wr and i_rd at the same edge:
  - Both are accepted; the write is ordered first.
  - The read therefore observes the new data, including when the addresses are equal.
- Full buffer: o_ready drops for the cycle after the edge that fills the buffer. It rises again the cycle after the next commit.
- Address wrap: addresses are taken modulo 2**AWIDTH with no checking.
- Array contents are not reset; contents after power-up are undefined.

## Timing
- Reset values (rst low, asynchronous):
  - FSM IDLE, FIFO empty, counters 0, rd_pending 0.
  - Array contents untouched.
  - Outputs: o_rvalid=0, o_rdata=0, o_ready=1, o_wb_empty=1.
- Reset mid-operation: any pending read is dropped and o_rvalid does not pulse. All uncommitted buffered writes are discarded.
- Read with an empty buffer: accepted at edge E, o_rvalid is high in the cycle after edge E+RD_LAT.
- Read behind writes: o_rvalid is high in the cycle after edge (last commit edge)+RD_LAT.
- Write commit: for a lone write accepted at E, the array is updated at E+WR_LAT.
- o_wb_empty deasserts in the cycle after a write is accepted. It reasserts after the last commit edge.
- Throughput: one write accept per cycle until full. At most one read is outstanding at a time.

## Structure
- Shared package mem_pkg holds:
  - the FSM state encodings (IDLE, WAIT_WB, RD_LAT);
  - default latency constants;
  - the FIFO entry layout {addr, data}.
- Sub-module wb_fifo: a synchronous FIFO of WB_DEPTH entries with push, pop, full, empty and head outputs. It uses the same clk and rst.
- The array is a single inferred memory with one write port and one synchronous read port.

## Test plan
- Write 0xABCD to 0x012 at edge 0, read 0x012 at edge 1 → commit at edge 3, o_rvalid high after edge 7 with o_rdata=0xABCD. o_wb_empty is low between edges 0 and 3.
- Read 0x020 with the buffer empty, accepted at edge 0 → exactly one o_rvalid cycle, after edge 4, with the value previously written.
- Six back-to-back writes to 0x100..0x105 (data 0x1000..0x1005) → o_ready low after the fifth accept, the sixth accepted after the commit at edge 6. Readback returns all six values.
- i_wr(0x033, 0x5A5A) and i_rd(0x033) on the same edge, old value 0x1111 → read returns 0x5A5A.
- rst pulsed low during a pending read with two buffered writes:
  - o_rvalid never pulses; o_ready=1 and o_wb_empty=1 during reset.
  - Afterwards, a read of both write addresses returns their pre-write values.
- Write to address 0x3FF and read 0x3FF, then write to 0x000 → no aliasing; each location reads back its own data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder.
// Holds the read-sequencer state encoding, the default geometry and latency
// constants, and the write-buffer entry layout: {addr, data}, with the
// address in the upper bits.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWaitWb = 2'd1,
    StRdLat  = 2'd2
  } rd_state_e;

  localparam int unsigned DefDwidth  = 16;
  localparam int unsigned DefAwidth  = 10;
  localparam int unsigned DefRdLat   = 4;
  localparam int unsigned DefWrLat   = 3;
  localparam int unsigned DefWbDepth = 4;

  // Width of one write-buffer entry {addr, data}.
  function automatic int unsigned entry_width(input int unsigned awidth,
                                              input int unsigned dwidth);
    return awidth + dwidth;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Write buffer: synchronous FIFO of DEPTH entries (DEPTH a power of two).
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   push         write push_data at the tail (caller keeps it off when full)
//   push_data    entry to store
//   pop          drop the head entry (caller keeps it off when empty)
//   full, empty  occupancy flags
//   last         exactly one entry held
//   head         oldest entry
module wb_fifo #(
  parameter int unsigned WIDTH = 26,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             last,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign last  = (count_q == CntW'(1));
  assign head  = store[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_responder.sv
// Slow-memory responder for the data cache's port B.
// Posted writes go through a write buffer and commit one every WR_LAT edges;
// a read waits until every buffered write has committed, then returns after
// RD_LAT edges. One read outstanding at a time.
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   i_wr, i_waddr, i_wdata  write request
//   i_rd, i_raddr         read request
//   o_ready               requests accepted at an edge only while high
//   o_rdata, o_rvalid     read data and its one-cycle valid pulse
//   o_wb_empty            no buffered or in-progress write
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DWIDTH   = DefDwidth,
  parameter int unsigned AWIDTH   = DefAwidth,
  parameter int unsigned RD_LAT   = DefRdLat,
  parameter int unsigned WR_LAT   = DefWrLat,
  parameter int unsigned WB_DEPTH = DefWbDepth
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [AWIDTH-1:0] i_waddr,
  input  logic              i_rd,
  input  logic [AWIDTH-1:0] i_raddr,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_wb_empty
);

  localparam int unsigned EntryW = entry_width(AWIDTH, DWIDTH);
  localparam int unsigned WrCntW = $clog2(WR_LAT + 1);
  localparam int unsigned RdCntW = $clog2(RD_LAT + 1);
  localparam int unsigned Words  = 2 ** AWIDTH;

  logic              wr_acc, rd_acc;
  logic              fifo_full, fifo_empty, fifo_last;
  logic [EntryW-1:0] head;
  logic [AWIDTH-1:0] commit_addr, rd_addr_now, rd_addr_q;
  logic [DWIDTH-1:0] commit_data, rd_data_q, rdata_q;
  logic              commit, rd_issue, rd_fwd;
  logic [WrCntW-1:0] wr_cnt_q;
  logic [RdCntW-1:0] rd_cnt_q;
  rd_state_e         state_q;
  logic              rd_pending_q, rvalid_q;
  logic [DWIDTH-1:0] mem [Words];

  assign o_ready    = !fifo_full && !rd_pending_q;
  assign wr_acc     = i_wr && o_ready;
  assign rd_acc     = i_rd && o_ready;
  assign o_wb_empty = fifo_empty;
  assign o_rdata    = rdata_q;
  assign o_rvalid   = rvalid_q;

  wb_fifo #(
    .WIDTH (EntryW),
    .DEPTH (WB_DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_acc),
    .push_data ({i_waddr, i_wdata}),
    .pop       (commit),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .last      (fifo_last),
    .head      (head)
  );

  assign {commit_addr, commit_data} = head;
  assign commit = !fifo_empty && (wr_cnt_q == WrCntW'(WR_LAT - 1));

  // The head counts edges; the commit edge restarts the count for the next entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q <= '0;
    end else if (commit) begin
      wr_cnt_q <= '0;
    end else if (!fifo_empty) begin
      wr_cnt_q <= wr_cnt_q + 1'b1;
    end
  end

  // A read issues at the first edge that leaves the buffer empty. That may be
  // the accept edge itself or the edge committing the last buffered write, in
  // which case the committing data is forwarded past the array.
  always_comb begin
    rd_addr_now = rd_addr_q;
    rd_issue    = 1'b0;
    case (state_q)
      StIdle: begin
        rd_addr_now = i_raddr;
        rd_issue    = rd_acc && !wr_acc && (fifo_empty || (commit && fifo_last));
      end
      StWaitWb: rd_issue = commit && fifo_last;
      default:  rd_issue = 1'b0;
    endcase
    rd_fwd = commit && (commit_addr == rd_addr_now);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rd_acc) begin
            rd_addr_q    <= i_raddr;
            rd_pending_q <= 1'b1;
            if (rd_issue) begin
              state_q  <= StRdLat;
              rd_cnt_q <= RdCntW'(RD_LAT);
            end else begin
              state_q <= StWaitWb;
            end
          end
        end
        StWaitWb: begin
          if (rd_issue) begin
            state_q  <= StRdLat;
            rd_cnt_q <= RdCntW'(RD_LAT);
          end
        end
        StRdLat: begin
          if (rd_cnt_q == RdCntW'(1)) begin
            rvalid_q     <= 1'b1;
            rdata_q      <= rd_data_q;
            rd_pending_q <= 1'b0;
            state_q      <= StIdle;
          end else begin
            rd_cnt_q <= rd_cnt_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Array: one write port, one synchronous read port; contents never reset.
  always_ff @(posedge clk) begin
    if (commit) mem[commit_addr] <= commit_data;
  end

  always_ff @(posedge clk) begin
    if (rd_issue) rd_data_q <= rd_fwd ? commit_data : mem[rd_addr_now];
  end

endmodule
